// File: rtl/square_iter.sv
// rtl/square_iter.sv - sequential Q8.8 squarer, 16-iteration shift-add, start/busy/done handshake
// Optional build macro SQUARE_ITER_SAT_EN: saturate out to 8'hFF when the integer part exceeds 255.
module square_iter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] in,
  output logic        busy,
  output logic        done,
  output logic [31:0] prod,
  output logic [7:0]  out,
  output logic        ovf
);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [31:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] prod_q, prod_d;
  logic [7:0]  out_q, out_d;
  logic        ovf_q, ovf_d;
  logic        done_q, done_d;
  logic [31:0] sum;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= 32'd0;
      b_q     <= 16'd0;
      acc_q   <= 32'd0;
      cnt_q   <= 4'd0;
      prod_q  <= 32'd0;
      out_q   <= 8'd0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    out_d   = out_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    // Peak square is 0xFFFE0001, so the 32-bit sum cannot carry out.
    sum     = acc_q + (b_q[0] ? a_q : 32'd0);

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = {16'd0, in};
          b_d     = in;
          acc_d   = 32'd0;
          cnt_d   = 4'd0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = sum;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          prod_d  = sum;
          ovf_d   = |sum[31:24];
`ifdef SQUARE_ITER_SAT_EN
          out_d   = (|sum[31:24]) ? 8'hFF : sum[23:16];
`else
          out_d   = sum[23:16];
`endif
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == CALC);
  assign done = done_q;
  assign prod = prod_q;
  assign out  = out_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_square_iter.sv
// tb/tb_square_iter.sv - scoreboard bench for square_iter with random and directed operands
// Expected out follows SQUARE_ITER_SAT_EN the same way the design build does.
module tb_square_iter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] in;
  logic        busy;
  logic        done;
  logic [31:0] prod;
  logic [7:0]  out;
  logic        ovf;

  square_iter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .in    (in),
    .busy  (busy),
    .done  (done),
    .prod  (prod),
    .out   (out),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] prod;
    logic [7:0]  out;
    logic        ovf;
    int          acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   n_done = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer square, then the Q16.16 integer-part rules.
  function automatic exp_t model(input logic [15:0] v, input int acc);
    exp_t e;
    logic [31:0] wide;
    wide      = {16'd0, v};
    e.prod    = wide * wide;
    e.ovf     = (e.prod >= 32'h0100_0000);
`ifdef SQUARE_ITER_SAT_EN
    e.out     = e.ovf ? 8'hFF : 8'((e.prod / 32'h1_0000) % 256);
`else
    e.out     = 8'((e.prod / 32'h1_0000) % 256);
`endif
    e.acc_cyc = acc;
    return e;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT reports a result.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      n_done++;
      check("done_while_busy", {31'd0, busy}, 32'd0);
      check("done_width", {31'd0, prev_done}, 32'd0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1, expected no result pending (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        check("prod", prod, e.prod);
        check("out", {24'd0, out}, {24'd0, e.out});
        check("ovf", {31'd0, ovf}, {31'd0, e.ovf});
        check("latency", 32'(cyc - e.acc_cyc), 32'd16);
      end
    end
    prev_done = done;
  end

  task automatic do_op(input logic [15:0] v);
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) check("idle_wait_timeout", 32'd1, 32'd0);
    start = 1'b1;
    in    = v;
    @(posedge clk);
    #1;
    exp_q.push_back(model(v, cyc));
    start = 1'b0;
    in    = 16'($urandom);
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || busy) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("drain_timeout", 32'd1, 32'd0);
  endtask

  logic [15:0] dir_v [6] = '{16'h0200, 16'h0180, 16'h0B50, 16'h1000, 16'hFFFF, 16'h0000};

  initial begin
    int e0;
    int e1;
    int done_before;
    rst_n = 1'b0;
    start = 1'b0;
    in    = 16'h0000;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_prod", prod, 32'd0);
    check("rst_out", {24'd0, out}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);

    foreach (dir_v[i]) do_op(dir_v[i]);
    for (int i = 0; i < 20; i++) do_op(16'($urandom));
    wait_drain();

    // Held start: first op on 0F00, then re-accept of 0200 in the done cycle.
    @(negedge clk);
    start = 1'b1;
    in    = 16'h0F00;
    @(posedge clk);
    #1;
    e0 = cyc;
    exp_q.push_back(model(16'h0F00, e0));
    exp_q.push_back(model(16'h0200, e0 + 17));
    repeat (3) @(posedge clk);
    #1 in = 16'h0200;
    while (cyc < e0 + 17) begin
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    e1 = cyc;
    @(negedge clk);
    check("rearm_busy", {31'd0, busy}, 32'd1);
    check("first_result_prod", prod, 32'h00E1_0000);
    while (cyc < e1 + 5) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    exp_q.delete();
    done_before = n_done;
    @(negedge clk);
    check("abort_busy_pre", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_prod", prod, 32'd0);
    check("abort_out", {24'd0, out}, 32'd0);
    check("abort_ovf", {31'd0, ovf}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (25) @(negedge clk);
    check("no_done_after_abort", 32'(n_done - done_before), 32'd0);

    do_op(16'h0180);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected completion before 200000 time units");
    $fatal(1, "watchdog");
  end

endmodule
